// File: rtl/nine_segment_pkg.sv
// rtl/nine_segment_pkg.sv - shared 3x3 nine-segment geometry, types and helpers
package nine_segment_pkg;

    localparam int NUM_ROWS     = 3;
    localparam int NUM_COLS     = 3;
    localparam int NUM_SEGMENTS = NUM_ROWS * NUM_COLS;

    typedef logic [1:0]              scan_phase_t;
    typedef logic [NUM_ROWS-1:0]     row_vec_t;
    typedef logic [NUM_COLS-1:0]     col_vec_t;
    typedef logic [NUM_SEGMENTS-1:0] frame_t;

    typedef enum logic [1:0] {
        ROW_BLANK     = 2'd0,
        ROW_ONE_HOT   = 2'd1,
        ROW_MULTI_HOT = 2'd2
    } row_class_t;

    function automatic logic [3:0] seg_index(input scan_phase_t row, input logic [1:0] col);
        return 4'(row) * 4'(NUM_COLS) + 4'(col);
    endfunction

    function automatic scan_phase_t phase_inc(input scan_phase_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/six_pin_to_nine_segment_if.sv
// rtl/six_pin_to_nine_segment_if.sv - six-pin drive in, decoded frame and status out
interface six_pin_to_nine_segment_if;
    import nine_segment_pkg::*;

    row_vec_t rows;
    col_vec_t cols;
    frame_t   segments;
    logic     frame_valid;
    logic     frame_changed;
    logic     scan_error;
    logic     locked;

    modport master (
        output rows, cols,
        input  segments, frame_valid, frame_changed, scan_error, locked
    );

    modport slave (
        input  rows, cols,
        output segments, frame_valid, frame_changed, scan_error, locked
    );

endinterface

// File: rtl/scan_phase_tracker.sv
// rtl/scan_phase_tracker.sv - modulo-3 scan phase and row-drive classification
module scan_phase_tracker
    import nine_segment_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  row_vec_t    rows,
    output scan_phase_t phase,
    output logic        row_blank,
    output logic        row_match,
    output logic        realign,
    output scan_phase_t realign_row,
    output logic        error
);

    scan_phase_t phase_q;
    scan_phase_t phase_d;
    row_class_t  row_class;
    scan_phase_t hot_row;

    always_comb begin
        row_class = ROW_MULTI_HOT;
        hot_row   = 2'd0;
        case (rows)
            3'b000:  row_class = ROW_BLANK;
            3'b001:  begin row_class = ROW_ONE_HOT; hot_row = 2'd0; end
            3'b010:  begin row_class = ROW_ONE_HOT; hot_row = 2'd1; end
            3'b100:  begin row_class = ROW_ONE_HOT; hot_row = 2'd2; end
            default: row_class = ROW_MULTI_HOT;
        endcase
    end

    // A blank sample stands in for the expected row, so it always matches.
    always_comb begin
        row_blank   = (row_class == ROW_BLANK);
        row_match   = row_blank || (row_class == ROW_ONE_HOT && hot_row == phase_q);
        realign     = (row_class == ROW_ONE_HOT) && (hot_row != phase_q);
        realign_row = hot_row;
        error       = realign || (row_class == ROW_MULTI_HOT);
        phase       = phase_q;
    end

    always_comb begin
        phase_d = phase_inc(phase_q);
        if (realign) begin
            phase_d = phase_inc(hot_row);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/six_pin_to_nine_segment.sv
// rtl/six_pin_to_nine_segment.sv - rebuilds 9-bit segment frames from the multiplexed six-pin scan
module six_pin_to_nine_segment
    import nine_segment_pkg::*;
#(
    parameter int INPUT_REG   = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    six_pin_to_nine_segment_if.slave   pins
);

    localparam logic [3:0] LOCK_MAX = 4'(LOCK_FRAMES);

    row_vec_t s_rows;
    col_vec_t s_cols;

    generate
        if (INPUT_REG != 0) begin : g_in_reg
            row_vec_t rows_q;
            row_vec_t rows_d;
            col_vec_t cols_q;
            col_vec_t cols_d;

            always_comb begin
                rows_d = pins.rows;
                cols_d = pins.cols;
            end

            // Reset values read as a blank row with no lit columns.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rows_q <= '0;
                    cols_q <= '1;
                end else begin
                    rows_q <= rows_d;
                    cols_q <= cols_d;
                end
            end

            assign s_rows = rows_q;
            assign s_cols = cols_q;
        end else begin : g_no_reg
            assign s_rows = pins.rows;
            assign s_cols = pins.cols;
        end
    endgenerate

    scan_phase_t phase;
    scan_phase_t realign_row;
    logic        row_blank;
    logic        row_match;
    logic        realign;
    logic        error;

    scan_phase_tracker u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .rows        (s_rows),
        .phase       (phase),
        .row_blank   (row_blank),
        .row_match   (row_match),
        .realign     (realign),
        .realign_row (realign_row),
        .error       (error)
    );

    frame_t     row_buf_q,   row_buf_d;
    row_vec_t   seen_q,      seen_d;
    frame_t     segments_q,  segments_d;
    logic       valid_q,     valid_d;
    logic       changed_q,   changed_d;
    logic       error_q,     error_d;
    logic       locked_q,    locked_d;
    logic [3:0] lock_cnt_q,  lock_cnt_d;
    col_vec_t   row_bits;

    always_comb begin
        row_buf_d  = row_buf_q;
        seen_d     = seen_q;
        segments_d = segments_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        error_d    = error;
        locked_d   = locked_q;
        lock_cnt_d = lock_cnt_q;
        row_bits   = row_blank ? '0 : ~s_cols;

        if (error && !realign) begin
            seen_d     = '0;
            row_buf_d  = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (realign) begin
            // Restart assembly from the row actually being driven.
            seen_d              = '0;
            seen_d[realign_row] = 1'b1;
            for (int c = 0; c < NUM_COLS; c++) begin
                row_buf_d[seg_index(realign_row, 2'(c))] = ~s_cols[c];
            end
            lock_cnt_d = '0;
            locked_d   = 1'b0;
        end else if (row_match) begin
            seen_d[phase] = 1'b1;
            for (int c = 0; c < NUM_COLS; c++) begin
                row_buf_d[seg_index(phase, 2'(c))] = row_bits[c];
            end
            if (phase == 2'd2) begin
                if (seen_d == 3'b111) begin
                    segments_d = row_buf_d;
                    valid_d    = 1'b1;
                    changed_d  = (row_buf_d != segments_q);
                    if (lock_cnt_q < LOCK_MAX) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                    end
                    locked_d = (lock_cnt_d == LOCK_MAX);
                end
                seen_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf_q  <= '0;
            seen_q     <= '0;
            segments_q <= '0;
            valid_q    <= 1'b0;
            changed_q  <= 1'b0;
            error_q    <= 1'b0;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            row_buf_q  <= row_buf_d;
            seen_q     <= seen_d;
            segments_q <= segments_d;
            valid_q    <= valid_d;
            changed_q  <= changed_d;
            error_q    <= error_d;
            locked_q   <= locked_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end

    assign pins.segments      = segments_q;
    assign pins.frame_valid   = valid_q;
    assign pins.frame_changed = changed_q;
    assign pins.scan_error    = error_q;
    assign pins.locked        = locked_q;

endmodule

// File: tb/tb_six_pin_to_nine_segment.sv
// tb/tb_six_pin_to_nine_segment.sv - scoreboard bench for six_pin_to_nine_segment
module tb_six_pin_to_nine_segment;

    typedef struct packed {
        logic [8:0] seg;
        logic       chg;
        logic       lck;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_errors;
    int   seen_errors;
    logic prev_valid;
    exp_t exp_q[$];

    six_pin_to_nine_segment_if bus();

    six_pin_to_nine_segment #(
        .INPUT_REG   (1),
        .LOCK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] c);
        bus.rows = r;
        bus.cols = c;
        @(negedge clk);
    endtask

    task automatic frame(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                         input logic [8:0] seg, input logic chg, input logic lck);
        exp_q.push_back('{seg: seg, chg: chg, lck: lck});
        drive(3'b001, c0);
        drive(3'b010, c1);
        drive(3'b100, c2);
    endtask

    task automatic blank_frame(input logic lck);
        exp_q.push_back('{seg: 9'd0, chg: 1'b0, lck: lck});
        repeat (3) drive(3'b000, 3'b111);
    endtask

    task automatic center_frame(input logic chg, input logic lck);
        exp_q.push_back('{seg: 9'b000010000, chg: chg, lck: lck});
        drive(3'b000, 3'b101);
        drive(3'b010, 3'b101);
        drive(3'b000, 3'b101);
    endtask

    // Release at a falling edge; the reset-valued input register counts as blank row 0.
    task automatic release_reset();
        rst_n = 1'b1;
        exp_q.push_back('{seg: 9'd0, chg: 1'b0, lck: 1'b0});
        drive(3'b000, 3'b111);
        drive(3'b000, 3'b111);
    endtask

    always @(posedge clk) begin
        #1;
        if (bus.frame_valid) begin
            if (prev_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL valid_width: got 2-cycle pulse expected 1-cycle");
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame: got segments %b expected no frame", bus.segments);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_segments", bus.segments, e.seg);
                check("frame_changed", {8'd0, bus.frame_changed}, {8'd0, e.chg});
                check("frame_locked", {8'd0, bus.locked}, {8'd0, e.lck});
            end
        end
        if (bus.scan_error) begin
            seen_errors++;
            check("locked_on_error", {8'd0, bus.locked}, 9'd0);
        end
        prev_valid = bus.frame_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        exp_errors  = 0;
        seen_errors = 0;
        prev_valid  = 1'b0;
        rst_n       = 1'b0;
        bus.rows    = 3'b101;
        bus.cols    = 3'b010;

        repeat (4) begin
            @(negedge clk);
            bus.rows = 3'($urandom);
            bus.cols = 3'($urandom);
        end
        check("rst_segments", bus.segments, 9'd0);
        check("rst_valid", {8'd0, bus.frame_valid}, 9'd0);
        check("rst_changed", {8'd0, bus.frame_changed}, 9'd0);
        check("rst_error", {8'd0, bus.scan_error}, 9'd0);
        check("rst_locked", {8'd0, bus.locked}, 9'd0);

        release_reset();

        repeat (3) blank_frame(1'b1);

        center_frame(1'b1, 1'b1);
        center_frame(1'b0, 1'b1);

        frame(3'b010, 3'b101, 3'b010, 9'b101010101, 1'b1, 1'b1);

        exp_errors++;
        drive(3'b100, 3'b000);
        frame(3'b110, 3'b111, 3'b011, 9'b100000001, 1'b1, 1'b0);
        frame(3'b110, 3'b111, 3'b011, 9'b100000001, 1'b0, 1'b1);

        exp_errors++;
        drive(3'b001, 3'b000);
        drive(3'b011, 3'b000);
        drive(3'b100, 3'b000);
        exp_q.push_back('{seg: 9'b101010101, chg: 1'b1, lck: 1'b0});
        drive(3'b001, 3'b010);
        drive(3'b010, 3'b101);
        check("hold_after_multihot", bus.segments, 9'b100000001);
        drive(3'b100, 3'b010);
        frame(3'b010, 3'b101, 3'b010, 9'b101010101, 1'b0, 1'b1);

        drive(3'b001, 3'b000);
        drive(3'b010, 3'b000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_segments", bus.segments, 9'd0);
        check("async_rst_locked", {8'd0, bus.locked}, 9'd0);
        check("async_rst_valid", {8'd0, bus.frame_valid}, 9'd0);
        bus.rows = 3'($urandom);
        bus.cols = 3'($urandom);
        repeat (2) @(negedge clk);

        release_reset();
        center_frame(1'b1, 1'b1);

        drive(3'b000, 3'b111);
        drive(3'b000, 3'b111);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("scan_error_count", 9'(seen_errors), 9'(exp_errors));
        check("frames_outstanding", 9'(exp_q.size()), 9'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
